// File: rtl/mipi_align_pkg.sv
// Shared types and helpers for the MIPI D-PHY lane-align controller.
package mipi_align_pkg;

   localparam int LANES_MAX = 8;

   typedef enum logic [2:0] {IDLE, ARRIVE, STREAM, DRAIN, FLUSH} state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_SKEW    = 2'd1;
   localparam logic [1:0] ERR_FAIL    = 2'd2;
   localparam logic [1:0] ERR_RESTART = 2'd3;

   // Active-lane mask for a configured lane count; 0 or out-of-range selects all lanes.
   function automatic logic [LANES_MAX-1:0] act_mask(input logic [2:0] num, input int lanes);
      int n;
      n = (num == 3'd0 || int'(num) > lanes) ? lanes : int'(num);
      act_mask = '0;
      for (int i = 0; i < LANES_MAX; i++)
         if (i < n) act_mask[i] = 1'b1;
   endfunction

endpackage

// File: rtl/mipi_lane_rise_det.sv
// Per-lane valid history register and rising-edge detect.
module mipi_lane_rise_det #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] valid,
   output logic [N-1:0] rise
);

   logic [N-1:0] valid_q, valid_d;

   // Next history value is simply the current raw valid.
   always_comb valid_d = valid;

   // One-cycle history of the raw lane valids.
   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   assign rise = valid & ~valid_q;

endmodule

// File: rtl/mipi_lane_align_ctrl.sv
// Burst sequencer for the multi-lane byte aligner: arrival skew window,
// stream/drain tracking, aligner clear on errors, lane masking, statistics.
// Optional: define LANE_SKEW_STAT_EN to add the per-lane lane_skew report.
module mipi_lane_align_ctrl
   import mipi_align_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int SKEW_MAX     = 4,
   parameter int SKEW_W       = 4,
   parameter int DRAIN_CYCLES = 6,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                byte_clk,
   input  logic                sys_rst,
   input  logic [2:0]          cfg_lane_num,
   input  logic [LANES-1:0]    lanes_valid,
   input  logic                align_out_valid,
   input  logic                align_fail,
   output logic                aligner_clr,
   output logic [LANES-1:0]    lane_mask,
   output logic                burst_active,
   output logic                burst_done,
   output logic                burst_err,
   output logic [1:0]          err_code,
   output logic [15:0]         burst_cnt,
   output logic [15:0]         fail_cnt,
   output logic [SKEW_W-1:0]   skew_max
`ifdef LANE_SKEW_STAT_EN
   ,output logic [LANES*SKEW_W-1:0] lane_skew
`endif
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [SKEW_W-1:0]  SKEW_LIM   = SKEW_W'(SKEW_MAX);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LEN  = FLUSH_W'(FLUSH_CYCLES);

   logic [LANES-1:0] rise;

   mipi_lane_rise_det #(.N(LANES)) u_rise (
      .clk   (byte_clk),
      .rst   (sys_rst),
      .valid (lanes_valid),
      .rise  (rise)
   );

   state_t               state_q, state_d;
   logic [LANES-1:0]     act_q, act_d, arrived_q, arrived_d;
   logic [SKEW_W-1:0]    skew_cnt_q, skew_cnt_d, burst_skew_q, burst_skew_d;
   logic [SKEW_W-1:0]    skew_max_q, skew_max_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic                 clr_q, clr_d, done_q, done_d, err_q, err_d, active_q, active_d;
   logic [1:0]           err_code_q, err_code_d;
   logic [15:0]          burst_cnt_q, burst_cnt_d, fail_cnt_q, fail_cnt_d;

   logic [LANES_MAX-1:0] act_full;
   logic [LANES-1:0]     rise_act, live_act, arr_next;
   logic [SKEW_W-1:0]    skew_inc;
   logic                 go_flush;
   logic [1:0]           flush_code;
   logic                 unused_sig;

   // align_out_valid is observation-only; upper mask bits exist only for narrow builds.
   assign unused_sig = ^{align_out_valid, act_full};

   // Burst FSM next-state, error classification and statistics update.
   always_comb begin
      act_full     = act_mask(cfg_lane_num, LANES);
      rise_act     = rise & act_q;
      live_act     = lanes_valid & act_q;
      skew_inc     = skew_cnt_q + SKEW_W'(1);
      arr_next     = arrived_q | rise_act;
      state_d      = state_q;
      act_d        = act_q;
      arrived_d    = arrived_q;
      skew_cnt_d   = skew_cnt_q;
      burst_skew_d = burst_skew_q;
      skew_max_d   = skew_max_q;
      drain_cnt_d  = drain_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      clr_d        = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      burst_cnt_d  = burst_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      go_flush     = 1'b0;
      flush_code   = ERR_NONE;
      case (state_q)
         IDLE: begin
            if (|rise_act) begin
               arrived_d    = rise_act;
               skew_cnt_d   = '0;
               burst_skew_d = '0;
               state_d      = (rise_act == act_q) ? STREAM : ARRIVE;
            end else begin
               // Lane count only takes effect between bursts.
               act_d = act_full[LANES-1:0];
            end
         end
         ARRIVE: begin
            skew_cnt_d = skew_inc;
            arrived_d  = arr_next;
            if (arr_next == act_q) begin
               state_d      = STREAM;
               burst_skew_d = skew_inc;
            end else if (skew_inc == SKEW_LIM) begin
               go_flush   = 1'b1;
               flush_code = ERR_SKEW;
            end
         end
         STREAM: begin
            if (align_fail) begin
               go_flush   = 1'b1;
               flush_code = ERR_FAIL;
            end else if (|(rise_act & arrived_q)) begin
               go_flush   = 1'b1;
               flush_code = ERR_RESTART;
            end else if (live_act == '0) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            if (align_fail) begin
               go_flush   = 1'b1;
               flush_code = ERR_FAIL;
            end else if (|rise_act) begin
               go_flush   = 1'b1;
               flush_code = ERR_RESTART;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               done_d      = 1'b1;
               burst_cnt_d = (burst_cnt_q == 16'hFFFF) ? burst_cnt_q : burst_cnt_q + 16'd1;
               // Burst skew never exceeds SKEW_MAX, which fits SKEW_W, so max() is already saturated.
               skew_max_d  = (burst_skew_q > skew_max_q) ? burst_skew_q : skew_max_q;
               err_code_d  = ERR_NONE;
               state_d     = IDLE;
            end
         end
         FLUSH: begin
            if (flush_cnt_q != FLUSH_LEN) begin
               clr_d       = 1'b1;
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end else if (live_act == '0) begin
               // Only rearm once the lanes are idle so a mid-burst flush cannot restart alignment.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (go_flush) begin
         state_d     = FLUSH;
         err_d       = 1'b1;
         err_code_d  = flush_code;
         fail_cnt_d  = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
         clr_d       = 1'b1;
         flush_cnt_d = FLUSH_W'(1);
      end
      active_d = (state_d == ARRIVE) || (state_d == STREAM) || (state_d == DRAIN);
   end

   // State and registered outputs.
   always_ff @(posedge byte_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         act_q        <= '1;
         arrived_q    <= '0;
         skew_cnt_q   <= '0;
         burst_skew_q <= '0;
         skew_max_q   <= '0;
         drain_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         clr_q        <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         active_q     <= 1'b0;
         err_code_q   <= ERR_NONE;
         burst_cnt_q  <= '0;
         fail_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         act_q        <= act_d;
         arrived_q    <= arrived_d;
         skew_cnt_q   <= skew_cnt_d;
         burst_skew_q <= burst_skew_d;
         skew_max_q   <= skew_max_d;
         drain_cnt_q  <= drain_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         clr_q        <= clr_d;
         done_q       <= done_d;
         err_q        <= err_d;
         active_q     <= active_d;
         err_code_q   <= err_code_d;
         burst_cnt_q  <= burst_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
      end
   end

   assign aligner_clr  = clr_q;
   assign lane_mask    = act_q;
   assign burst_active = active_q;
   assign burst_done   = done_q;
   assign burst_err    = err_q;
   assign err_code     = err_code_q;
   assign burst_cnt    = burst_cnt_q;
   assign fail_cnt     = fail_cnt_q;
   assign skew_max     = skew_max_q;

`ifdef LANE_SKEW_STAT_EN
   logic [LANES-1:0][SKEW_W-1:0] lane_off_q, lane_off_d, lane_skew_q, lane_skew_d;

   // Per-lane arrival offsets for the burst in flight; published on clean completion.
   always_comb begin
      lane_off_d  = lane_off_q;
      lane_skew_d = lane_skew_q;
      if (state_q == IDLE) begin
         lane_off_d = '0;
      end else if (state_q == ARRIVE) begin
         for (int i = 0; i < LANES; i++)
            if (rise_act[i] && !arrived_q[i]) lane_off_d[i] = skew_inc;
      end
      if (done_d) lane_skew_d = lane_off_q;
   end

   // Offset tracking and last-clean-burst report registers.
   always_ff @(posedge byte_clk) begin
      if (sys_rst) begin
         lane_off_q  <= '0;
         lane_skew_q <= '0;
      end else begin
         lane_off_q  <= lane_off_d;
         lane_skew_q <= lane_skew_d;
      end
   end

   assign lane_skew = lane_skew_q;
`endif

endmodule

// File: tb/tb_mipi_lane_align_ctrl.sv
// Randomized burst-scenario bench for mipi_lane_align_ctrl. Each scenario is
// planned as per-lane rise/drop times; outcome and pulse timing are predicted
// arithmetically from those times and compared with what the DUT produced.
module tb_mipi_lane_align_ctrl;

   localparam int LANES        = 4;
   localparam int SKEW_MAX     = 4;
   localparam int SKEW_W       = 4;
   localparam int DRAIN_CYCLES = 6;
   localparam int FLUSH_CYCLES = 2;

   logic                byte_clk = 1'b0;
   logic                sys_rst;
   logic [2:0]          cfg_lane_num;
   logic [LANES-1:0]    lanes_valid;
   logic                align_out_valid;
   logic                align_fail;
   logic                aligner_clr;
   logic [LANES-1:0]    lane_mask;
   logic                burst_active, burst_done, burst_err;
   logic [1:0]          err_code;
   logic [15:0]         burst_cnt, fail_cnt;
   logic [SKEW_W-1:0]   skew_max;
`ifdef LANE_SKEW_STAT_EN
   logic [LANES*SKEW_W-1:0] lane_skew;
`endif

   always #5 byte_clk = ~byte_clk;

   mipi_lane_align_ctrl #(
      .LANES(LANES), .SKEW_MAX(SKEW_MAX), .SKEW_W(SKEW_W),
      .DRAIN_CYCLES(DRAIN_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .byte_clk        (byte_clk),
      .sys_rst         (sys_rst),
      .cfg_lane_num    (cfg_lane_num),
      .lanes_valid     (lanes_valid),
      .align_out_valid (align_out_valid),
      .align_fail      (align_fail),
      .aligner_clr     (aligner_clr),
      .lane_mask       (lane_mask),
      .burst_active    (burst_active),
      .burst_done      (burst_done),
      .burst_err       (burst_err),
      .err_code        (err_code),
      .burst_cnt       (burst_cnt),
      .fail_cnt        (fail_cnt),
      .skew_max        (skew_max)
`ifdef LANE_SKEW_STAT_EN
      ,.lane_skew      (lane_skew)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference statistics.
   int                      m_burst = 0;
   int                      m_fail  = 0;
   int                      m_skew  = 0;
   int                      m_code  = 0;
   logic [LANES*SKEW_W-1:0] m_lskew = '0;

   logic [LANES-1:0] wave  [0:127];
   logic             failw [0:127];

   // kind: 0 clean, 1 skew timeout, 2 align_fail, 3 restart in drain.
   task automatic run_scn(input int kind, input logic [2:0] cfg, input bit dir);
      int nl, m, mn, mx, S, D, E, ev, L, k, hold;
      int off [LANES];
      int drop[LANES];
      int n_done, n_errp, n_clr, t_done, t_err, t_clr;
      logic [LANES-1:0] act;
      logic act_seen;
      nl  = (cfg == 3'd0 || int'(cfg) > LANES) ? LANES : int'(cfg);
      act = LANES'((1 << nl) - 1);
      if (kind == 1 && nl < 2) kind = 0;

      // Quiet gap so the new lane count is latched.
      cfg_lane_num = cfg;
      repeat (3) begin
         @(negedge byte_clk);
         lanes_valid = '0;
         align_fail  = 1'b0;
      end
      @(posedge byte_clk); #1;
      chk("lane_mask", 32'(lane_mask), 32'(act));

      // Plan arrival offsets and drop times.
      m  = (kind == 1) ? (dir ? nl - 1 : int'($urandom_range(0, nl - 1))) : -1;
      mn = 99;
      mx = 0;
      for (int i = 0; i < LANES; i++) begin off[i] = 0; drop[i] = 0; end
      for (int i = 0; i < nl; i++) if (i != m) begin
         off[i] = dir ? ((kind == 1) ? 0 : i)
                      : int'($urandom_range(0, (kind == 1) ? SKEW_MAX - 1 : SKEW_MAX));
         if (off[i] < mn) mn = off[i];
      end
      for (int i = 0; i < nl; i++) if (i != m) begin
         off[i] -= mn;
         if (off[i] > mx) mx = off[i];
      end
      S = 2 + mx;
      E = 2 + SKEW_MAX;
      D = 0;
      for (int i = 0; i < nl; i++) if (i != m) begin
         drop[i] = ((kind == 1) ? E + 1 : S + 1) + int'($urandom_range(0, 8));
         if (drop[i] > D) D = drop[i];
      end
      for (int t = 0; t < 128; t++) begin wave[t] = '0; failw[t] = 1'b0; end
      for (int i = 0; i < nl; i++) if (i != m)
         for (int t = 2 + off[i]; t < drop[i]; t++) wave[t][i] = 1'b1;

      ev = 0;
      case (kind)
         1: begin ev = E; L = ((D > E + 2) ? D : E + 2) + 4; end
         2: begin
            ev = int'($urandom_range(S + 1, D + DRAIN_CYCLES));
            failw[ev] = 1'b1;
            L = ((D > ev + 2) ? D : ev + 2) + 4;
         end
         3: begin
            k    = int'($urandom_range(0, nl - 1));
            ev   = int'($urandom_range(D + 1, D + DRAIN_CYCLES));
            hold = int'($urandom_range(1, 4));
            for (int t = ev; t < ev + hold; t++) wave[t][k] = 1'b1;
            L = ev + hold + 6;
         end
         default: L = D + DRAIN_CYCLES + 4;
      endcase
      // Unused lanes chatter; they must be ignored.
      for (int t = 0; t < L - 1; t++)
         for (int i = nl; i < LANES; i++) wave[t][i] = 1'($urandom_range(0, 1));

      n_done = 0; n_errp = 0; n_clr = 0; t_done = -1; t_err = -1; t_clr = -1;
      act_seen = 1'b0;
      for (int t = 0; t < L; t++) begin
         @(negedge byte_clk);
         lanes_valid     = wave[t];
         align_fail      = failw[t];
         align_out_valid = 1'($urandom_range(0, 1));
         @(posedge byte_clk); #1;
         if (burst_done)  begin n_done++; t_done = t; end
         if (burst_err)   begin n_errp++; t_err = t; end
         if (aligner_clr) begin n_clr++; if (t_clr < 0) t_clr = t; end
         if (t == 2) act_seen = burst_active;
      end

      chk("active_mid", 32'(act_seen), 32'd1);
      if (kind == 0) begin
         if (m_burst < 65535) m_burst++;
         if (mx > m_skew) m_skew = mx;
         if (m_skew > (1 << SKEW_W) - 1) m_skew = (1 << SKEW_W) - 1;
         m_code  = 0;
         m_lskew = '0;
         for (int i = 0; i < nl; i++) m_lskew[i*SKEW_W +: SKEW_W] = SKEW_W'(off[i]);
         chk("done_pulses", n_done, 1);
         chk("done_cycle", t_done, D + DRAIN_CYCLES);
         chk("err_pulses", n_errp, 0);
         chk("clr_cycles", n_clr, 0);
      end else begin
         if (m_fail < 65535) m_fail++;
         m_code = kind;
         chk("err_pulses", n_errp, 1);
         chk("err_cycle", t_err, ev);
         chk("clr_first", t_clr, ev);
         chk("clr_cycles", n_clr, FLUSH_CYCLES);
         chk("done_pulses", n_done, 0);
      end
      chk("burst_cnt", 32'(burst_cnt), m_burst);
      chk("fail_cnt", 32'(fail_cnt), m_fail);
      chk("err_code", 32'(err_code), m_code);
      chk("skew_max", 32'(skew_max), m_skew);
      chk("active_end", 32'(burst_active), 32'd0);
`ifdef LANE_SKEW_STAT_EN
      chk("lane_skew", 32'(lane_skew), 32'(m_lskew));
`endif
   endtask

   initial begin
      sys_rst         = 1'b1;
      cfg_lane_num    = 3'd4;
      lanes_valid     = '0;
      align_out_valid = 1'b0;
      align_fail      = 1'b0;
      repeat (2) @(posedge byte_clk);
      #1;
      chk("rst_mask", 32'(lane_mask), 32'hF);
      chk("rst_active", 32'(burst_active), 0);
      chk("rst_done", 32'(burst_done), 0);
      chk("rst_err", 32'(burst_err), 0);
      chk("rst_clr", 32'(aligner_clr), 0);
      chk("rst_code", 32'(err_code), 0);
      chk("rst_bcnt", 32'(burst_cnt), 0);
      chk("rst_fcnt", 32'(fail_cnt), 0);
      chk("rst_skew", 32'(skew_max), 0);
      @(negedge byte_clk);
      sys_rst = 1'b0;

      // Directed: staggered clean burst, missing lane, align_fail, 2-lane config, restart.
      run_scn(0, 3'd4, 1'b1);
      run_scn(1, 3'd4, 1'b1);
      run_scn(2, 3'd4, 1'b0);
      run_scn(0, 3'd2, 1'b0);
      run_scn(3, 3'd4, 1'b0);
      for (int n = 0; n < 40; n++)
         run_scn(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0);

      // Reset in the middle of a stream.
      cfg_lane_num = 3'd4;
      repeat (3) begin
         @(negedge byte_clk);
         lanes_valid = '0;
         align_fail  = 1'b0;
      end
      @(negedge byte_clk);
      lanes_valid = 4'hF;
      repeat (3) @(negedge byte_clk);
      @(posedge byte_clk); #1;
      chk("pre_rst_active", 32'(burst_active), 1);
      @(negedge byte_clk);
      sys_rst = 1'b1;
      @(posedge byte_clk); #1;
      chk("mid_rst_active", 32'(burst_active), 0);
      chk("mid_rst_bcnt", 32'(burst_cnt), 0);
      chk("mid_rst_fcnt", 32'(fail_cnt), 0);
      chk("mid_rst_skew", 32'(skew_max), 0);
      chk("mid_rst_code", 32'(err_code), 0);
      chk("mid_rst_mask", 32'(lane_mask), 32'hF);
      chk("mid_rst_clr", 32'(aligner_clr), 0);
      @(negedge byte_clk);
      sys_rst     = 1'b0;
      lanes_valid = '0;
      repeat (2) @(posedge byte_clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
